apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase cycles before abort; 0 disables timeout.
REQ-004 PCLK  input  1  single clock; all logic on rising edge.
REQ-005 PRESETn  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at PCLK edge.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts).
REQ-014 rsp_err  output  1  PSLVERR or timeout occurred.
REQ-015 rsp_timeout  output  1  transfer aborted by timeout.
REQ-016 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-017 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH.
REQ-018 PRDATA  input  DATA_WIDTH; PREADY, PSLVERR  input  1 each.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS, RESP; one transfer in flight; no pipelining.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a handshake latches write/addr/wdata and moves to SETUP.
REQ-021 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from latched command; always exactly one cycle, then ACCESS.
REQ-022 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL remain stable until the phase ends.
REQ-023 ACCESS ends on a PCLK edge with PREADY=1: capture PRDATA (reads only) into rsp_rdata, capture PSLVERR into rsp_err, rsp_timeout=0, go to RESP.
REQ-024 PSLVERR and PRDATA SHALL be ignored unless PSEL && PENABLE && PREADY.
REQ-025 Timeout: counter clears on SETUP entry, increments each ACCESS cycle without PREADY; at TIMEOUT_CYCLES such cycles go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 PREADY=1 on the same edge the timeout would fire SHALL complete normally (PREADY wins).
REQ-027 RESP: PSEL=0, PENABLE=0, rsp_valid=1, response fields stable; on rsp_ready go to IDLE.
REQ-028 Minimum latency: handshake at edge N, SETUP cycle N..N+1, ACCESS N+1..N+2, PREADY=1 at edge N+2 gives rsp_valid=1 after edge N+2; next command accepted no earlier than edge after rsp handshake.
REQ-029 PADDR/PWRITE/PWDATA SHALL hold their last values in IDLE/RESP; PSEL=0 there.
REQ-030 rsp_valid SHALL never be 1 outside RESP; cmd_valid outside IDLE SHALL have no effect.

Reset
REQ-031 PRESETn low SHALL asynchronously force IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout=0; PADDR, PWDATA, rsp_rdata=0; timeout counter=0; cmd_ready=1 after release.
REQ-032 Reset during SETUP/ACCESS SHALL drop PSEL/PENABLE immediately; aborted transfer produces no response.

Structure
REQ-033 Package apb_pkg SHALL hold the FSM state encoding and default width/timeout constants.
REQ-034 One sub-module apb_timeout_ctr (clear, enable, expired output, parameter TIMEOUT_CYCLES) SHALL implement the timeout counter.

Verification
REQ-035 Write 0x0000_00A5 to 0x1000_0008, PREADY=1 constant -> SETUP one cycle, ACCESS one cycle, rsp_valid after 2 edges, rsp_err=0, rsp_rdata=0.
REQ-036 Read 0x1000_0004, PREADY low 3 ACCESS cycles then high with PRDATA=0x0000_005A -> PADDR/PWRITE stable 4 ACCESS cycles, rsp_rdata=0x5A.
REQ-037 Read 0x1000_0010 with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
REQ-038 TIMEOUT_CYCLES=4, PREADY stuck 0 -> after 4 ACCESS cycles PSEL/PENABLE drop, rsp_err=1, rsp_timeout=1; PREADY asserted on the 4th cycle instead -> normal completion.
REQ-039 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> response fields stable, cmd_ready=0, no new SETUP until rsp handshake.
REQ-040 PRESETn asserted mid-ACCESS -> PSEL/PENABLE=0 same cycle, no rsp_valid, next command after release completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding, default widths/timeout,
// and the sizing helper used by the timeout counter.
package apb_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    // The counter only needs to reach n-1 before the expiring cycle is flagged.
    function automatic int ctr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals for one APB master.
// The master modport is the master's view; slave is the environment (command source + APB target).
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS cycles spent waiting for PREADY; expired flags the cycle that would be
// the TIMEOUT_CYCLES-th such cycle. TIMEOUT_CYCLES = 0 disables the timeout entirely.
module apb_timeout_ctr
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = PCLK ^ PRESETn ^ clear ^ enable;
            assign expired  = 1'b0;
        end else begin : g_ctr
            localparam int CW = ctr_width(TIMEOUT_CYCLES);

            logic [CW-1:0] r_count;
            logic          w_at_limit;

            assign w_at_limit = (r_count == CW'(TIMEOUT_CYCLES - 1));
            assign expired    = enable && w_at_limit;

            // Saturates at the limit; the FSM leaves ACCESS on the expiring cycle anyway.
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable && !w_at_limit) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one command, runs SETUP/ACCESS on APB,
// and holds the response (data, slave error, timeout) until it is consumed.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);

    apb_state_t r_state;
    apb_state_t w_next_state;

    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic w_cmd_fire;
    logic w_access_done;
    logic w_access_wait;
    logic w_expired;
    logic w_timeout_fire;
    logic w_rsp_fire;

    assign w_cmd_fire     = (r_state == ST_IDLE) && bus.cmd_valid;
    // PREADY only counts while the bus is in its ACCESS phase (PSEL && PENABLE).
    assign w_access_done  = (r_state == ST_ACCESS) && bus.PREADY;
    assign w_access_wait  = (r_state == ST_ACCESS) && !bus.PREADY;
    assign w_timeout_fire = w_access_wait && w_expired;
    assign w_rsp_fire     = (r_state == ST_RESP) && bus.rsp_ready;

    apb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (r_state == ST_SETUP),
        .enable  (w_access_wait),
        .expired (w_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_cmd_fire) w_next_state = ST_SETUP;
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_access_done || w_timeout_fire) w_next_state = ST_RESP;
            ST_RESP:   if (w_rsp_fire) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        unique case (r_state)
            ST_IDLE:   bus.cmd_ready = 1'b1;
            ST_SETUP:  bus.PSEL      = 1'b1;
            ST_ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
            end
            ST_RESP:   bus.rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    // Address/control/data only change on a command handshake, so they stay frozen
    // through SETUP, ACCESS and RESP and keep their last values while idle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_cmd_fire) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
        end
    end

    // PREADY takes priority over an expiring timeout on the same edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_access_done) begin
            r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
            r_rsp_err     <= bus.PSLVERR;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout_fire) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end
    end

    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Table-driven bench for apb_master: a vector table feeds command + APB target behaviour,
// expected responses go through a scoreboard queue; reset corners are hand-written.
module tb_apb_master;

    localparam int TO = 4;

    logic clk;
    logic rst_n;

    apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waitc;     // ACCESS cycles with PREADY low before PREADY high
        logic [31:0] prdata;
        logic        slverr;
        int          hold;      // cycles rsp_ready is held low (cmd_valid kept high)
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    vec_t vecs[9];
    rsp_t sb_q[$];

    int n_vec   = 0;
    int n_check = 0;
    int n_miss  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        rsp_t        exp;
        rsp_t        snap;
        int          k;
        bit          done;
        @(negedge clk);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_psel", bus.PSEL, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
        n_vec++;

        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("setup_psel", bus.PSEL, 1);
        chk("setup_penable", bus.PENABLE, 0);
        chk("setup_paddr", bus.PADDR, v.addr);
        chk("setup_pwrite", bus.PWRITE, v.wr);
        chk("setup_pwdata", bus.PWDATA, v.wdata);
        chk("setup_cmd_ready", bus.cmd_ready, 0);
        chk("setup_rsp_valid", bus.rsp_valid, 0);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hDEAD_BEEF;

        k    = 0;
        done = 1'b0;
        while (!done && k < 64) begin
            @(negedge clk);
            chk("access_psel", bus.PSEL, 1);
            chk("access_penable", bus.PENABLE, 1);
            chk("access_paddr", bus.PADDR, v.addr);
            chk("access_pwrite", bus.PWRITE, v.wr);
            chk("access_pwdata", bus.PWDATA, v.wdata);
            chk("access_rsp_valid", bus.rsp_valid, 0);
            if (k == v.waitc) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = v.prdata;
                bus.PSLVERR = v.slverr;
                done        = 1'b1;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = 32'hDEAD_0000 ^ k;
                bus.PSLVERR = 1'b1;
                if (k == TO - 1) done = 1'b1;
            end
            k++;
        end
        if (!done) chk("access_bound", 0, 1);

        @(negedge clk);
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        chk("resp_rsp_valid", bus.rsp_valid, 1);
        chk("resp_psel", bus.PSEL, 0);
        chk("resp_penable", bus.PENABLE, 0);
        chk("resp_paddr_hold", bus.PADDR, v.addr);
        chk("resp_cmd_ready", bus.cmd_ready, 0);
        snap = '{bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};

        for (int h = 0; h < v.hold; h++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = ~v.wr;
            bus.cmd_addr  = 32'hBAD0_0000 + h;
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_psel", bus.PSEL, 0);
            chk("hold_rdata", bus.rsp_rdata, snap.rdata);
            chk("hold_err", bus.rsp_err, snap.err);
            chk("hold_to", bus.rsp_timeout, snap.to);
            chk("hold_paddr", bus.PADDR, v.addr);
        end

        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            exp = sb_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, exp.rdata);
            chk("rsp_err", bus.rsp_err, exp.err);
            chk("rsp_timeout", bus.rsp_timeout, exp.to);
        end
        $display("vec %0d: %s addr=0x%08h rdata=0x%08h err=%0b to=%0b", n_vec,
                 v.wr ? "WR" : "RD", v.addr, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);

        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("post_rsp_valid", bus.rsp_valid, 0);
        chk("post_cmd_ready", bus.cmd_ready, 1);
        chk("post_psel", bus.PSEL, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    addr          wdata         wait prdata        err  hold exp_rdata     e_err e_to
        vecs[0] = '{1'b1, 32'h1000_0008, 32'h0000_00A5, 0,   32'h1111_1111, 1'b0, 0, 32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h1000_0004, 32'h0000_0000, 3,   32'h0000_005A, 1'b0, 0, 32'h0000_005A, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h1000_0010, 32'h0000_0000, 0,   32'h0000_0077, 1'b1, 0, 32'h0000_0077, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h1000_0014, 32'h0000_0000, 100, 32'h5555_5555, 1'b0, 0, 32'h0,         1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h1000_0018, 32'h0000_0000, TO-1, 32'h0000_1234, 1'b0, 0, 32'h0000_1234, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h2000_0000, 32'hFFFF_0001, 2,   32'h9999_9999, 1'b1, 0, 32'h0,         1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h3000_0100, 32'h0000_0000, 1,   32'hCAFE_BABE, 1'b0, 0, 32'hCAFE_BABE, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h4000_0004, 32'h1234_5678, 0,   32'h0,         1'b0, 5, 32'h0,         1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'h5000_0000, 32'hA5A5_A5A5, 100, 32'h0,         1'b0, 2, 32'h0,         1'b1, 1'b1};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        #1;
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", bus.cmd_ready, 1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of an ACCESS phase: bus drops at once, no response appears.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h1000_0020;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        chk("rstseq_setup_psel", bus.PSEL, 1);
        @(negedge clk);
        chk("rstseq_access_penable", bus.PENABLE, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstseq_psel", bus.PSEL, 0);
        chk("rstseq_penable", bus.PENABLE, 0);
        chk("rstseq_rsp_valid", bus.rsp_valid, 0);
        chk("rstseq_paddr", bus.PADDR, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstseq_no_rsp", bus.rsp_valid, 0);
            chk("rstseq_cmd_ready", bus.cmd_ready, 1);
            chk("rstseq_idle_psel", bus.PSEL, 0);
        end
        run_vec(vecs[6]);
        run_vec(vecs[0]);

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
